id_ex_hazard_stage: RTL and testbench
=====================================

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath width.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset); one clock, reset is asynchronous and active-low.
REQ-003 SHALL have id_valid (in, 1), meaning the ID stage holds a real instruction.
REQ-004 SHALL have id_pc, id_rs1_data, id_rs2_data and id_imm (in, XLEN each), the decoded operands.
REQ-005 SHALL have id_rs1, id_rs2 and id_rd (in, 5 each), the register indices.
REQ-006 SHALL have id_funct (in, 4), instr[30] concatenated with instr[14:12].
REQ-007 SHALL have id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc and id_regwrite (in, 1 each), plus id_aluop (in, 2), all from the control unit.
REQ-008 SHALL have flush (in, 1), meaning a taken branch was resolved downstream.
REQ-009 SHALL have stall (out, 1), which drives the control unit's stall input.
REQ-010 SHALL have pc_write and ifid_write (out, 1 each), the PC and IF/ID register enables.
REQ-011 SHALL have registered EX-side outputs ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite and ex_aluop, each the same width as its id_ counterpart.
REQ-012 SHALL have stall_count and flush_count (out, 32 each), the performance counters.

Function
REQ-013 SHALL compute load_use combinationally: id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-014 SHALL drive stall = load_use & ~flush; flush overrides stall.
REQ-015 SHALL drive pc_write = ifid_write = ~stall.
REQ-016 SHALL, on a rising clk edge with flush=1, load a bubble into ID/EX: ex_valid and all ex_ control bits 0, ex_aluop 2'b00.
REQ-017 SHALL, on a rising clk edge with stall=1, load the same bubble as REQ-016.
REQ-018 SHALL, in both the flush and stall cases, hold the data fields (ex_pc, ex_*_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct) at their previous values.
REQ-019 SHALL, on a rising edge with flush=0 and stall=0, capture every id_ field into its ex_ counterpart.
REQ-020 SHALL, in the REQ-019 case, set ex_valid = id_valid and gate each control bit and aluop with id_valid, so an invalid ID slot becomes a bubble.
REQ-021 SHALL have a latency of exactly one clock from ID inputs to ex_ outputs; no combinational path from id_ inputs to ex_ outputs.
REQ-022 SHALL increment stall_count by 1 on each edge where stall=1, saturating at 32'hFFFF_FFFF.
REQ-023 SHALL increment flush_count by 1 on each edge where flush=1, saturating at 32'hFFFF_FFFF.
REQ-024 SHALL count a cycle with flush=1 and load_use=1 as a flush only, not as a stall.
REQ-025 SHALL NOT stall for a hazard on x0 (ex_rd == 0), nor when the EX slot is a store, ALU or branch op (ex_memread=0).
REQ-026 SHALL limit each load-use hazard to exactly one stall cycle: the bubble clears ex_memread, so stall deasserts on the next cycle with the ID inputs held.
REQ-027 SHALL NOT use id_memwrite or id_regwrite of the instruction in ID to qualify the hazard; only register-index matching qualifies it.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, drive every ex_ output, ex_valid, stall_count and flush_count to 0.
REQ-029 SHALL, while rst_n=0, have stall=0 and pc_write=ifid_write=1, because ex_valid=0.
REQ-030 SHALL, when rst_n is asserted mid-stall or mid-flush, discard the pending bubble or capture; the first edge after deassertion behaves per REQ-019 using that cycle's inputs.

Verification
REQ-031 Load-use, rs1 match: ld x5 in EX (ex_memread=1, ex_rd=5), ID add with id_rs1=5 -> stall=1 and pc_write=0 for one cycle; next edge ex_valid=0; following edge captures the add; stall_count=1.
REQ-032 Load-use, rs2 match: ID add with id_rs2=5 against ld x5 in EX -> same response as REQ-031.
REQ-033 Zero register and non-load: ex_rd=0 with id_rs1=0, or an R-type in EX with ex_rd=5 and id_rs1=5 -> stall=0 and normal capture.
REQ-034 Simultaneous flush and load-use: flush=1 in the hazard cycle -> stall=0, pc_write=1, bubble loaded, flush_count+1, stall_count unchanged.
REQ-035 Invalid slot: id_valid=0 with id_regwrite=1 -> ex_valid=0 and ex_regwrite=0 after the edge.
REQ-036 Saturation and async reset: force stall_count to 32'hFFFF_FFFF, apply another stall -> value stays 32'hFFFF_FFFF; pulse rst_n low between edges -> all ex_ outputs and both counters read 0 immediately.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall, flush bubbles and perf counters
module id_ex_hazard_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_funct,
    input  logic            id_branch,
    input  logic            id_memread,
    input  logic            id_memtoreg,
    input  logic            id_memwrite,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic [1:0]      id_aluop,
    input  logic            flush,
    output logic            stall,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_aluop,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);
    logic        w_load_use;
    logic        w_bubble;
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    assign w_load_use  = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign stall       = w_load_use & ~flush;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign w_bubble    = flush | stall;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    // Bubbles clear only valid/control; data fields keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct    <= 4'd0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
        end else if (w_bubble) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            ex_branch   <= id_branch & id_valid;
            ex_memread  <= id_memread & id_valid;
            ex_memtoreg <= id_memtoreg & id_valid;
            ex_memwrite <= id_memwrite & id_valid;
            ex_alusrc   <= id_alusrc & id_valid;
            ex_regwrite <= id_regwrite & id_valid;
            ex_aluop    <= id_aluop & {2{id_valid}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (stall && r_stall_count != 32'hFFFF_FFFF)
                r_stall_count <= r_stall_count + 32'd1;
            if (flush && r_flush_count != 32'hFFFF_FFFF)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: slot-level reference model plus directed hazard/flush/reset scenarios
module tb_id_ex_hazard_stage;
    typedef struct packed {
        logic        valid;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic        br, mr, mtr, mw, as, rw;
        logic [1:0]  op;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, flush;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]  id_aluop;
    logic        stall, pc_write, ifid_write;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic        ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop;
    logic [31:0] stall_count, flush_count;

    int    n_chk = 0;
    int    n_err = 0;
    slot_t m_ex;
    logic [31:0] m_stalls, m_flushes;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .flush(flush), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_aluop(ex_aluop), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic slot_t id_slot();
        slot_t s;
        s = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct,
              id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_aluop};
        if (!id_valid) {s.br, s.mr, s.mtr, s.mw, s.as, s.rw, s.op} = '0;
        return s;
    endfunction

    function automatic slot_t dut_slot();
        return '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
                 ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop};
    endfunction

    // A load in EX writing a nonzero register that the ID instruction reads.
    function automatic logic model_hazard();
        return id_valid && m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
               (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (flush) m_flushes = (m_flushes == 32'hFFFF_FFFF) ? m_flushes : m_flushes + 1;
            else if (model_hazard()) m_stalls = (m_stalls == 32'hFFFF_FFFF) ? m_stalls : m_stalls + 1;
            if (flush || model_hazard()) begin
                m_ex.valid = 0;
                {m_ex.br, m_ex.mr, m_ex.mtr, m_ex.mw, m_ex.as, m_ex.rw, m_ex.op} = '0;
            end else m_ex = id_slot();
        end
    end

    always @(negedge clk) begin
        chk("ex_slot", 320'(dut_slot()), 320'(m_ex));
        chk("stall", 320'(stall), 320'(model_hazard() && !flush));
        chk("pc_write", 320'(pc_write), 320'(!(model_hazard() && !flush)));
        chk("ifid_write", 320'(ifid_write), 320'(!(model_hazard() && !flush)));
        chk("stall_count", 320'(stall_count), 320'(m_stalls));
        chk("flush_count", 320'(flush_count), 320'(m_flushes));
    end

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic rw, input logic [63:0] pc);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_pc = pc;
        id_rs1_data = pc ^ 64'hA5A5_5A5A_0F0F_F0F0; id_rs2_data = ~pc; id_imm = pc << 3;
        id_funct = pc[3:0]; id_branch = pc[4]; id_memread = mr; id_memtoreg = mr;
        id_memwrite = pc[5] & ~mr; id_alusrc = mr | pc[6]; id_regwrite = rw; id_aluop = pc[8:7];
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(name, 320'(act), 320'(exp));
    endtask

    initial begin
        rst_n = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 64'h0);
        cyc(); cyc();
        lit("rst_ex_valid", 64'(ex_valid), 0);
        lit("rst_pc_write", 64'(pc_write), 1);
        lit("rst_stall_count", 64'(stall_count), 0);
        rst_n = 1;
        drive(1, 1, 2, 5, 1, 1, 64'h1000);
        cyc();
        drive(1, 5, 6, 7, 0, 1, 64'h1004);
        #1 lit("rs1_stall", 64'(stall), 1);
        lit("rs1_pc_write", 64'(pc_write), 0);
        cyc();
        lit("rs1_bubble", 64'(ex_valid), 0);
        lit("rs1_hold_rd", 64'(ex_rd), 5);
        lit("rs1_stall_drop", 64'(stall), 0);
        cyc();
        lit("rs1_capture_rd", 64'(ex_rd), 7);
        lit("rs1_capture_pc", ex_pc, 64'h1004);
        lit("rs1_stall_count", 64'(stall_count), 1);
        drive(1, 1, 2, 5, 1, 1, 64'h2000);
        cyc();
        drive(1, 3, 5, 7, 0, 1, 64'h2004);
        #1 lit("rs2_stall", 64'(stall), 1);
        cyc();
        lit("rs2_bubble", 64'(ex_valid), 0);
        cyc();
        lit("rs2_stall_count", 64'(stall_count), 2);
        drive(1, 1, 2, 0, 1, 1, 64'h3000);
        cyc();
        drive(1, 0, 3, 7, 0, 1, 64'h3004);
        #1 lit("x0_no_stall", 64'(stall), 0);
        cyc();
        drive(1, 1, 2, 5, 0, 1, 64'h3008);
        cyc();
        drive(1, 5, 3, 7, 0, 1, 64'h300C);
        #1 lit("rtype_no_stall", 64'(stall), 0);
        cyc();
        lit("rtype_capture", ex_pc, 64'h300C);
        drive(1, 1, 2, 5, 1, 1, 64'h4000);
        cyc();
        drive(1, 5, 3, 7, 0, 1, 64'h4004);
        flush = 1;
        #1 lit("flush_no_stall", 64'(stall), 0);
        lit("flush_pc_write", 64'(pc_write), 1);
        cyc();
        flush = 0;
        lit("flush_bubble", 64'(ex_valid), 0);
        lit("flush_count", 64'(flush_count), 1);
        lit("flush_stall_count", 64'(stall_count), 2);
        cyc();
        drive(0, 1, 2, 9, 0, 1, 64'h5000);
        cyc();
        lit("inv_valid", 64'(ex_valid), 0);
        lit("inv_regwrite", 64'(ex_regwrite), 0);
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom});
            flush = ($urandom_range(0, 5) == 0);
            cyc();
        end
        flush = 0;
        dut.r_stall_count = 32'hFFFF_FFFF;
        m_stalls = 32'hFFFF_FFFF;
        drive(1, 1, 2, 5, 1, 1, 64'h6000);
        cyc();
        drive(1, 5, 3, 7, 0, 1, 64'h6004);
        cyc();
        lit("sat_stall_count", 64'(stall_count), 64'hFFFF_FFFF);
        drive(1, 1, 2, 5, 1, 1, 64'h7000);
        cyc();
        drive(1, 5, 3, 7, 0, 1, 64'h7004);
        rst_n = 0;
        #1 lit("arst_valid", 64'(ex_valid), 0);
        lit("arst_pc", ex_pc, 0);
        lit("arst_rd", 64'(ex_rd), 0);
        lit("arst_memread", 64'(ex_memread), 0);
        lit("arst_stall_count", 64'(stall_count), 0);
        lit("arst_flush_count", 64'(flush_count), 0);
        lit("arst_pc_write", 64'(pc_write), 1);
        #1 rst_n = 1;
        cyc();
        lit("post_rst_capture", ex_pc, 64'h7004);
        lit("post_rst_valid", 64'(ex_valid), 1);
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
